// File: rtl/skew_fb_pkg.sv
// Shared types and decision encodings for the skew feedback generator.
package skew_fb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DECIDE = 2'd3
  } state_t;

  localparam logic [1:0] DEC_UP  = 2'b10;
  localparam logic [1:0] DEC_DN  = 2'b01;
  localparam logic [1:0] DEC_BAL = 2'b00;

endpackage

// File: rtl/conf_change_det.sv
// Flags any bit change of the monitored configuration bus relative to the previous cycle.
module conf_change_det #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] CONF,
  output logic         CHG
);

  logic [W-1:0] conf_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) conf_q <= '0;
    else        conf_q <= CONF;
  end

  assign CHG = (CONF != conf_q);

endmodule

// File: rtl/skew_feedback_gen.sv
// Windowed averaging of up/down comparator samples into registered O_INVU/O_INVD decisions,
// with settle blanking after config changes and a LOCKED flag for sustained balance.
module skew_feedback_gen
  import skew_fb_pkg::*;
#(
  parameter int CONF_W     = 4,
  parameter int WIN        = 16,
  parameter int THRESH     = 2,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_N     = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              SMP_VLD,
  input  logic              SMP_UP,
  input  logic              SMP_DN,
  input  logic [CONF_W-1:0] INVU_PCONF,
  input  logic [CONF_W-1:0] INVU_NCONF,
  input  logic [CONF_W-1:0] INVD_PCONF,
  input  logic [CONF_W-1:0] INVD_NCONF,
  output logic              O_INVU,
  output logic              O_INVD,
  output logic              DEC_VLD,
  output logic              LOCKED,
  output logic [1:0]        DBG_STATE
);

  localparam int CW = $clog2(WIN + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int LW = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'(WIN - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [LW-1:0] LOCK_MAX    = LW'(LOCK_N);
  localparam logic [CW:0]   THRESH_E    = (CW + 1)'(THRESH);

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q;
  logic [CW-1:0] up_q, dn_q, n_q;
  logic [LW-1:0] lock_q, lock_nxt;
  logic          chg;
  logic          settle_clr, settle_inc, win_clr, smp_take, dec_fire;
  logic [CW:0]   up_e, dn_e;
  logic [1:0]    dec_code;

  conf_change_det #(.W(4 * CONF_W)) u_chg (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CONF  ({INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF}),
    .CHG   (chg)
  );

  assign DBG_STATE = state_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    settle_clr = 1'b0;
    settle_inc = 1'b0;
    win_clr    = 1'b0;
    smp_take   = 1'b0;
    dec_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        settle_clr = 1'b1;
        win_clr    = 1'b1;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (chg) begin
          settle_clr = 1'b1;
        end else if (settle_q == SETTLE_LAST) begin
          settle_clr = 1'b1;
          win_clr    = 1'b1;
          state_d    = ACCUM;
        end else begin
          settle_inc = 1'b1;
        end
      end
      ACCUM: begin
        // A config change outranks a coincident sample: the partial window is discarded.
        if (chg) begin
          settle_clr = 1'b1;
          win_clr    = 1'b1;
          state_d    = SETTLE;
        end else if (SMP_VLD) begin
          smp_take = 1'b1;
          if (n_q == WIN_LAST) state_d = DECIDE;
        end
      end
      DECIDE: begin
        dec_fire   = 1'b1;
        settle_clr = 1'b1;
        state_d    = SETTLE;
      end
      default: state_d = IDLE;
    endcase
    if (!EN) begin
      state_d    = IDLE;
      settle_clr = 1'b1;
      settle_inc = 1'b0;
      win_clr    = 1'b1;
      smp_take   = 1'b0;
      dec_fire   = 1'b0;
    end
  end

  // Margins compared one bit wider so count+THRESH cannot wrap.
  always_comb begin
    up_e     = {1'b0, up_q};
    dn_e     = {1'b0, dn_q};
    dec_code = DEC_BAL;
    if (up_e > dn_e + THRESH_E)      dec_code = DEC_UP;
    else if (dn_e > up_e + THRESH_E) dec_code = DEC_DN;
    lock_nxt = (lock_q == LOCK_MAX) ? lock_q : lock_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      settle_q <= '0;
      up_q     <= '0;
      dn_q     <= '0;
      n_q      <= '0;
      lock_q   <= '0;
      O_INVU   <= 1'b0;
      O_INVD   <= 1'b0;
      DEC_VLD  <= 1'b0;
      LOCKED   <= 1'b0;
    end else begin
      if (settle_clr)      settle_q <= '0;
      else if (settle_inc) settle_q <= settle_q + 1'b1;

      if (win_clr) begin
        up_q <= '0;
        dn_q <= '0;
        n_q  <= '0;
      end else if (smp_take) begin
        n_q <= n_q + 1'b1;
        if (SMP_UP && !SMP_DN) up_q <= up_q + 1'b1;
        if (SMP_DN && !SMP_UP) dn_q <= dn_q + 1'b1;
      end

      DEC_VLD <= dec_fire;
      if (dec_fire) {O_INVU, O_INVD} <= dec_code;

      if (!EN) begin
        lock_q <= '0;
        LOCKED <= 1'b0;
      end else if (dec_fire) begin
        if (dec_code == DEC_BAL) begin
          lock_q <= lock_nxt;
          LOCKED <= (lock_nxt == LOCK_MAX);
        end else begin
          lock_q <= '0;
          LOCKED <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_skew_feedback_gen.sv
// Directed bench for skew_feedback_gen: a table of full windows plus hand-written
// sequences for config changes, EN drop and asynchronous reset.
module tb_skew_feedback_gen;
  import skew_fb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, smp_vld, smp_up, smp_dn;
  logic [3:0] invu_p, invu_n, invd_p, invd_n;
  logic       o_invu, o_invd, dec_vld, locked;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] up;
    logic [15:0] dn;
    logic [1:0]  exp_o;
    logic        exp_lock;
  } vec_t;

  vec_t vecs[13];

  skew_feedback_gen dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .EN         (en),
    .SMP_VLD    (smp_vld),
    .SMP_UP     (smp_up),
    .SMP_DN     (smp_dn),
    .INVU_PCONF (invu_p),
    .INVU_NCONF (invu_n),
    .INVD_PCONF (invd_p),
    .INVD_NCONF (invd_n),
    .O_INVU     (o_invu),
    .O_INVD     (o_invd),
    .DEC_VLD    (dec_vld),
    .LOCKED     (locked),
    .DBG_STATE  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Junk strobes (UP only) while blanked; DEC_VLD must stay low throughout.
  task automatic settle_junk(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      smp_vld = 1'b1;
      smp_up  = 1'b1;
      smp_dn  = 1'b0;
      step();
      chk({nm, " dec_vld low"}, {3'b0, dec_vld}, 4'h0);
    end
    smp_vld = 1'b0;
    smp_up  = 1'b0;
  endtask

  // Called at the first cycle of ACCUM; returns on the cycle DEC_VLD is high.
  task automatic send_window(input logic [15:0] up, input logic [15:0] dn,
                             input logic [1:0] exp_o, input logic exp_lock, input string nm);
    for (int k = 0; k < 16; k++) begin
      smp_vld = 1'b1;
      smp_up  = up[k];
      smp_dn  = dn[k];
      step();
    end
    smp_vld = 1'b0;
    smp_up  = 1'b0;
    smp_dn  = 1'b0;
    chk({nm, " state decide"}, {2'b0, dbg_state}, {2'b0, DECIDE});
    chk({nm, " dec_vld early"}, {3'b0, dec_vld}, 4'h0);
    step();
    chk({nm, " dec_vld"}, {3'b0, dec_vld}, 4'h1);
    chk({nm, " o"}, {2'b0, o_invu, o_invd}, {2'b0, exp_o});
    chk({nm, " locked"}, {3'b0, locked}, {3'b0, exp_lock});
  endtask

  initial begin
    vecs[0]  = '{16'hFFFF, 16'h0000, DEC_UP,  1'b0};
    vecs[1]  = '{16'hFE00, 16'h01FF, DEC_BAL, 1'b0};
    vecs[2]  = '{16'hFC00, 16'h03FF, DEC_DN,  1'b0};
    vecs[3]  = '{16'hFFFF, 16'hFFFF, DEC_BAL, 1'b0};
    vecs[4]  = '{16'h0000, 16'h0000, DEC_BAL, 1'b0};
    vecs[5]  = '{16'h00FF, 16'hFF00, DEC_BAL, 1'b0};
    vecs[6]  = '{16'hFF00, 16'h00FF, DEC_BAL, 1'b1};
    vecs[7]  = '{16'h00FF, 16'hFF00, DEC_BAL, 1'b1};
    vecs[8]  = '{16'h01FF, 16'h7E00, DEC_UP,  1'b0};
    vecs[9]  = '{16'h001F, 16'h00E0, DEC_BAL, 1'b0};
    vecs[10] = '{16'h003F, 16'h01C0, DEC_UP,  1'b0};
    vecs[11] = '{16'hFFC0, 16'hFE3F, DEC_DN,  1'b0};
    vecs[12] = '{16'h00E0, 16'h001F, DEC_BAL, 1'b0};

    rst_n = 1'b0; en = 1'b0; smp_vld = 1'b0; smp_up = 1'b0; smp_dn = 1'b0;
    invu_p = 4'h5; invu_n = 4'h3; invd_p = 4'hA; invd_n = 4'hC;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset o",       {2'b0, o_invu, o_invd}, 4'h0);
    chk("reset dec_vld", {3'b0, dec_vld}, 4'h0);
    chk("reset locked",  {3'b0, locked}, 4'h0);
    chk("reset state",   {2'b0, dbg_state}, {2'b0, IDLE});
    step();

    en = 1'b1;
    settle_junk(9, "initial settle");
    chk("accum entry", {2'b0, dbg_state}, {2'b0, ACCUM});
    for (int v = 0; v < 13; v++) begin
      send_window(vecs[v].up, vecs[v].dn, vecs[v].exp_o, vecs[v].exp_lock,
                  $sformatf("vec%0d", v));
      step();
      chk($sformatf("vec%0d dec_vld pulse", v), {3'b0, dec_vld}, 4'h0);
      settle_junk(7, $sformatf("vec%0d settle", v));
    end

    // Config change coincident with the 8th sample: window abandoned, re-settle.
    for (int k = 0; k < 7; k++) begin
      smp_vld = 1'b1; smp_up = 1'b0; smp_dn = 1'b1;
      step();
    end
    invu_p = 4'h6;
    step();
    chk("midwin chg state", {2'b0, dbg_state}, {2'b0, SETTLE});
    chk("midwin chg dec_vld", {3'b0, dec_vld}, 4'h0);
    settle_junk(8, "midwin resettle");
    send_window(16'h00FF, 16'hFF00, DEC_BAL, 1'b0, "fresh window");

    // Config change inside SETTLE restarts the blanking count.
    settle_junk(2, "pre chg settle");
    invd_n = 4'hD;
    settle_junk(9, "restarted settle");
    send_window(16'hFF00, 16'h00FF, DEC_BAL, 1'b0, "after restart");
    step();
    settle_junk(7, "settle b");

    // EN drop mid-window: IDLE next edge, no decision, lock history cleared.
    for (int k = 0; k < 5; k++) begin
      smp_vld = 1'b1; smp_up = 1'b1; smp_dn = 1'b0;
      step();
    end
    en = 1'b0;
    smp_vld = 1'b0;
    step();
    chk("en drop state",   {2'b0, dbg_state}, {2'b0, IDLE});
    chk("en drop dec_vld", {3'b0, dec_vld}, 4'h0);
    chk("en drop o hold",  {2'b0, o_invu, o_invd}, 4'h0);
    settle_junk(3, "idle");
    en = 1'b1;
    settle_junk(9, "re-enable settle");
    send_window(16'h00FF, 16'hFF00, DEC_BAL, 1'b0, "lock cleared");
    step();
    settle_junk(7, "settle c");
    send_window(16'hFFFF, 16'h0000, DEC_UP, 1'b0, "pre reset up");
    step();
    settle_junk(7, "settle d");

    // Asynchronous reset mid-window clears outputs without waiting for an edge.
    for (int k = 0; k < 4; k++) begin
      smp_vld = 1'b1; smp_up = 1'b1; smp_dn = 1'b0;
      step();
    end
    smp_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async rst o",       {2'b0, o_invu, o_invd}, 4'h0);
    chk("async rst dec_vld", {3'b0, dec_vld}, 4'h0);
    chk("async rst locked",  {3'b0, locked}, 4'h0);
    chk("async rst state",   {2'b0, dbg_state}, {2'b0, IDLE});
    step(); step();
    rst_n = 1'b1;
    settle_junk(9, "post reset settle");
    send_window(16'h0000, 16'hFFFF, DEC_DN, 1'b0, "post reset dn");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
